// File: rtl/hazard_fwd_if.sv
// Decode-side bundle between the ID stage and the hazard/forwarding unit.
// master = decode stage (drives the ID fields), slave = hazard_fwd_unit.
interface hazard_fwd_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned SEL_W = 2
);
   logic             id_valid;
   logic [REG_W-1:0] id_ra;
   logic [REG_W-1:0] id_rb;
   logic             id_use_a;
   logic             id_use_b;
   logic [REG_W-1:0] id_rw;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             br_taken;
   logic             pipe_hold;
   logic [SEL_W-1:0] fwd_a;
   logic [SEL_W-1:0] fwd_b;
   logic             stall;
   logic             flush_if_id;
   logic             flush_id_ex;

   modport master (
      output id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rw, id_reg_write, id_mem_read,
      output br_taken, pipe_hold,
      input  fwd_a, fwd_b, stall, flush_if_id, flush_id_ex
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rw, id_reg_write, id_mem_read,
      input  br_taken, pipe_hold,
      output fwd_a, fwd_b, stall, flush_if_id, flush_id_ex
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller: shadow pipe of in-flight destinations driving forward
// selects, load-use stalls and branch flushes. HAZARD_STATS_EN adds stall/flush counters.
module hazard_fwd_unit #(
   parameter int unsigned REG_W      = 5,
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned LOAD_LAT   = 2,
   parameter int unsigned ZERO_REG   = 31,
   parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic               clk,
   input  logic               reset,
   hazard_fwd_if.slave        bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]        stall_count,
   output logic [31:0]        flush_count
`endif
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rw;
      logic             reg_write;
      logic             mem_read;
   } entry_t;

   typedef struct packed {
      logic             hit;
      logic             load_use;
      logic [SEL_W-1:0] sel;
   } match_t;

   entry_t shadow_q [NUM_STAGES];
   entry_t shadow_d [NUM_STAGES];
   match_t match_a;
   match_t match_b;
   logic   load_use;
   logic   stall_int;

   // Youngest matching stage wins; a load still short of LOAD_LAT cannot be forwarded.
   function automatic match_t find_match(logic [REG_W-1:0] src, logic use_src);
      match_t m;
      m = '0;
      if (use_src && (src != REG_W'(ZERO_REG))) begin
         for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            if (!m.hit && shadow_q[s].valid && shadow_q[s].reg_write &&
                (shadow_q[s].rw == src)) begin
               m.hit      = 1'b1;
               m.load_use = shadow_q[s].mem_read && (s < LOAD_LAT);
               m.sel      = SEL_W'(s + 1);
            end
         end
      end
      return m;
   endfunction

   always_comb begin
      match_a   = find_match(bus.id_ra, bus.id_use_a & bus.id_valid);
      match_b   = find_match(bus.id_rb, bus.id_use_b & bus.id_valid);
      load_use  = match_a.load_use | match_b.load_use;
      stall_int = ~bus.br_taken & (load_use | bus.pipe_hold);
   end

   assign bus.stall       = ~reset & stall_int;
   assign bus.flush_if_id = ~reset & bus.br_taken;
   assign bus.flush_id_ex = ~reset & bus.br_taken;
   assign bus.fwd_a = (!reset && match_a.hit && !match_a.load_use) ? match_a.sel : '0;
   assign bus.fwd_b = (!reset && match_b.hit && !match_b.load_use) ? match_b.sel : '0;

   // Stall and flush both land as a bubble in stage 0; older stages keep advancing.
   always_comb begin
      shadow_d = shadow_q;
      if (!bus.pipe_hold) begin
         for (int unsigned s = 1; s < NUM_STAGES; s++) begin
            shadow_d[s] = shadow_q[s-1];
         end
         shadow_d[0].valid     = bus.id_valid & ~stall_int & ~bus.br_taken;
         shadow_d[0].rw        = bus.id_rw;
         shadow_d[0].reg_write = bus.id_reg_write;
         shadow_d[0].mem_read  = bus.id_mem_read;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '{default: '0};
      end else begin
         shadow_q <= shadow_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_int && !bus.pipe_hold && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (bus.br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios then random traffic, all outputs compared
// against a list-of-in-flight-instructions model built from the hazard rules.
module tb_hazard_fwd_unit;
   localparam int REG_W = 5;
   localparam int NS    = 3;
   localparam int LL    = 2;
   localparam int ZR    = 31;
   localparam int SEL_W = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_fwd_if #(.REG_W(REG_W), .SEL_W(SEL_W)) bus ();

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count;
   logic [31:0] flush_count;
`endif

   hazard_fwd_unit #(
      .REG_W(REG_W), .NUM_STAGES(NS), .LOAD_LAT(LL), .ZERO_REG(ZR), .SEL_W(SEL_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef HAZARD_STATS_EN
      ,
      .stall_count(stall_count),
      .flush_count(flush_count)
`endif
   );

   // Model: in-flight instructions by age (index 0 = just issued into EX).
   bit m_v [NS];
   int m_rw[NS];
   bit m_w [NS];
   bit m_l [NS];
   bit m_stall;
   int m_sc;
   int m_fc;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errs++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int sel_for(int r, bit use_src, output bit lu);
      lu = 1'b0;
      if (!bus.id_valid || !use_src || r == ZR) return 0;
      for (int s = 0; s < NS; s++) begin
         if (m_v[s] && m_w[s] && m_rw[s] == r) begin
            if (m_l[s] && s < LL) begin
               lu = 1'b1;
               return 0;
            end
            return s + 1;
         end
      end
      return 0;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NS; s++) begin
         m_v[s] = 0; m_rw[s] = 0; m_w[s] = 0; m_l[s] = 0;
      end
      m_sc = 0;
      m_fc = 0;
   endtask

   task automatic expect_all(input string tag);
      bit la, lb;
      int ea, eb;
      ea = sel_for(int'(bus.id_ra), bus.id_use_a, la);
      eb = sel_for(int'(bus.id_rb), bus.id_use_b, lb);
      m_stall = !bus.br_taken && (la || lb || bus.pipe_hold);
      check({tag, ".fwd_a"}, 32'(bus.fwd_a), ea);
      check({tag, ".fwd_b"}, 32'(bus.fwd_b), eb);
      check({tag, ".stall"}, 32'(bus.stall), 32'(m_stall));
      check({tag, ".flush_if_id"}, 32'(bus.flush_if_id), 32'(bus.br_taken));
      check({tag, ".flush_id_ex"}, 32'(bus.flush_id_ex), 32'(bus.br_taken));
`ifdef HAZARD_STATS_EN
      check({tag, ".stall_count"}, stall_count, m_sc);
      check({tag, ".flush_count"}, flush_count, m_fc);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_stall && !bus.pipe_hold) m_sc++;
      if (bus.br_taken) m_fc++;
      if (!bus.pipe_hold) begin
         for (int s = NS - 1; s > 0; s--) begin
            m_v[s] = m_v[s-1]; m_rw[s] = m_rw[s-1]; m_w[s] = m_w[s-1]; m_l[s] = m_l[s-1];
         end
         m_v[0]  = bus.id_valid && !m_stall && !bus.br_taken;
         m_rw[0] = int'(bus.id_rw);
         m_w[0]  = bus.id_reg_write;
         m_l[0]  = bus.id_mem_read;
      end
      #1;
   endtask

   task automatic drive(input bit v, input int ra, input int rb, input bit ua, input bit ub,
                        input int rw, input bit wr, input bit ld, input bit br, input bit hold);
      bus.id_valid     = v;
      bus.id_ra        = REG_W'(ra);
      bus.id_rb        = REG_W'(rb);
      bus.id_use_a     = ua;
      bus.id_use_b     = ub;
      bus.id_rw        = REG_W'(rw);
      bus.id_reg_write = wr;
      bus.id_mem_read  = ld;
      bus.br_taken     = br;
      bus.pipe_hold    = hold;
   endtask

   task automatic settle(input string tag);
      #1;
      expect_all(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".fwd_a"}, 32'(bus.fwd_a), 0);
      check({tag, ".fwd_b"}, 32'(bus.fwd_b), 0);
      check({tag, ".stall"}, 32'(bus.stall), 0);
      check({tag, ".flush_if_id"}, 32'(bus.flush_if_id), 0);
      check({tag, ".flush_id_ex"}, 32'(bus.flush_id_ex), 0);
   endtask

   initial begin
      model_clear();
      m_stall = 0;
      reset = 1'b1;
      drive(1, 1, 2, 1, 1, 3, 1, 0, 1, 1);
      #1;
      check_all_zero("reset_busy_inputs");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #11;
      reset = 1'b0;

      // ADD X1, then reader of X1 (writes X4), then reader of X1 two behind.
      drive(1, 5, 6, 0, 0, 1, 1, 0, 0, 0); settle("add_x1"); tick();
      drive(1, 1, 0, 1, 0, 4, 1, 0, 0, 0); settle("use_x1_s0");
      check("plan_fwd_a_1", 32'(bus.fwd_a), 1); check("plan_stall_0", 32'(bus.stall), 0);
      tick();
      drive(1, 1, 0, 1, 0, 8, 0, 0, 0, 0); settle("use_x1_s1");
      check("plan_fwd_a_2", 32'(bus.fwd_a), 2);
      tick();

      // LDUR X2 then reader of X2 on B: stalls until the load reaches stage LOAD_LAT.
      drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); settle("ldur_x2"); tick();
      drive(1, 0, 2, 0, 1, 7, 1, 0, 0, 0); settle("lu_s0");
      check("plan_lu_stall_s0", 32'(bus.stall), 1); check("plan_lu_fwd_b0", 32'(bus.fwd_b), 0);
      tick();
      settle("lu_s1");
      check("plan_lu_stall_s1", 32'(bus.stall), 1);
      tick();
      settle("lu_s2");
      check("plan_lu_fwd_b3", 32'(bus.fwd_b), 3); check("plan_lu_stall_off", 32'(bus.stall), 0);
      tick();

      // Two producers of X3: youngest wins.
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); settle("x3_old"); tick();
      settle("x3_young"); tick();
      drive(1, 3, 3, 1, 1, 10, 0, 0, 0, 0); settle("x3_read");
      check("plan_youngest", 32'(bus.fwd_a), 1);
      tick();

      // XZR never forwards.
      drive(1, 0, 0, 0, 0, 31, 1, 0, 0, 0); settle("w_xzr"); tick();
      drive(1, 31, 31, 1, 1, 11, 0, 0, 0, 0); settle("r_xzr");
      check("plan_xzr_fwd", 32'(bus.fwd_a), 0); check("plan_xzr_stall", 32'(bus.stall), 0);
      tick();

      // Load-use coinciding with a taken branch: flush wins, bubble enters stage 0.
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); settle("ld_x5"); tick();
      drive(1, 0, 5, 0, 1, 9, 1, 0, 1, 0); settle("lu_br");
      check("plan_br_stall", 32'(bus.stall), 0);
      check("plan_br_flush_if", 32'(bus.flush_if_id), 1);
      check("plan_br_flush_ex", 32'(bus.flush_id_ex), 1);
      tick();
      drive(1, 9, 0, 1, 0, 12, 0, 0, 0, 0); settle("after_br");
      check("plan_br_bubble", 32'(bus.fwd_a), 0);
      tick();

      // Hold freezes the shadow with a producer at stage 0, then async reset mid-hold.
      drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); settle("prod_x6"); tick();
      drive(1, 6, 0, 1, 0, 13, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         settle("hold");
         check("plan_hold_fwd", 32'(bus.fwd_a), 1); check("plan_hold_stall", 32'(bus.stall), 1);
         tick();
      end
      reset = 1'b1;
      #1;
      check_all_zero("reset_mid_hold");
      model_clear();
      #1;
      reset = 1'b0;
      drive(1, 6, 0, 1, 0, 13, 1, 0, 0, 0); settle("post_reset");
      check("plan_post_reset_stall", 32'(bus.stall), 0);
      tick();

      // Random traffic over a small register pool so matches are frequent.
      for (int i = 0; i < 400; i++) begin
         int ra, rb, rw;
         ra = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 5));
         rb = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 5));
         rw = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 5));
         drive($urandom_range(0, 9) != 0, ra, rb, 1'($urandom), 1'($urandom), rw,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
         settle("rand");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
